// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo front end.
//  - opcode encodings (inst[3:0])
//  - reservation-station class codes carried on iss_cls
//  - issue-queue FSM state encoding
//  - decode helpers used by the slot-select chain
package tomasulo_pkg;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_BNE = 4'b0010;
   localparam logic [3:0] OP_LD  = 4'b0011;
   localparam logic [3:0] OP_SD  = 4'b0100;

   localparam logic [1:0] CLS_ADD = 2'b00;
   localparam logic [1:0] CLS_LD  = 2'b01;
   localparam logic [1:0] CLS_SD  = 2'b10;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_BR_WAIT = 1'b1
   } iq_state_t;

   // Every opcode above OP_SD is undefined and gets discarded at the head.
   function automatic logic op_legal(input logic [3:0] op);
      return (op <= OP_SD);
   endfunction

   // ADD, SUB and BNE all execute in the adder reservation stations.
   function automatic logic [1:0] op_cls(input logic [3:0] op);
      logic [1:0] cls;
      cls = CLS_ADD;
      if (op == OP_LD)
         cls = CLS_LD;
      else if (op == OP_SD)
         cls = CLS_SD;
      return cls;
   endfunction

endpackage

// File: rtl/tomasulo_issue_queue_slot_select.sv
// iq_slot_select: combinational in-order issue chain over the ISSUE_W oldest
// queue entries.
// Ports:
//  enable      in   dispatch permitted this cycle (Run, FSM in RUN, out of reset)
//  count       in   occupied queue entries
//  head_op     in   opcodes of entries head+0 .. head+ISSUE_W-1
//  add_free    in   free adder-RS entries
//  ld_free     in   free load-buffer entries
//  sd_free     in   free store-buffer entries
//  slot_valid  out  per-slot dispatch
//  slot_cls    out  per-slot class (zero for slots not dispatched)
//  illegal     out  an illegal opcode is consumed this cycle
//  deq_cnt     out  entries leaving the queue (dispatched + illegal-consumed)
//  bne_issued  out  a BNE dispatched this cycle
module iq_slot_select
   import tomasulo_pkg::*;
#(
   parameter int ISSUE_W = 2,
   parameter int CNT_W   = 2,
   parameter int OCC_W   = 5
) (
   input  logic                   enable,
   input  logic [OCC_W-1:0]       count,
   input  logic [ISSUE_W*4-1:0]   head_op,
   input  logic [CNT_W-1:0]       add_free,
   input  logic [CNT_W-1:0]       ld_free,
   input  logic [CNT_W-1:0]       sd_free,
   output logic [ISSUE_W-1:0]     slot_valid,
   output logic [ISSUE_W*2-1:0]   slot_cls,
   output logic                   illegal,
   output logic [CNT_W-1:0]       deq_cnt,
   output logic                   bne_issued
);

   // alive[i]: every older slot dispatched and none of them was a BNE.
   logic [ISSUE_W-1:0]            alive;
   logic [ISSUE_W-1:0]            slot_ill;
   logic [ISSUE_W-1:0]            slot_bne;
   // Same-class slots already dispatched ahead of slot i this cycle.
   logic [ISSUE_W-1:0][CNT_W-1:0] add_used;
   logic [ISSUE_W-1:0][CNT_W-1:0] ld_used;
   logic [ISSUE_W-1:0][CNT_W-1:0] sd_used;

   assign alive[0]    = enable;
   assign add_used[0] = '0;
   assign ld_used[0]  = '0;
   assign sd_used[0]  = '0;

   genvar gi;
   generate
      for (gi = 0; gi < ISSUE_W; gi++) begin : g_slot
         logic [3:0] op;
         logic [1:0] cls;
         logic       exists;
         logic       legal;
         logic       credit_ok;

         assign op     = head_op[gi*4 +: 4];
         assign cls    = op_cls(op);
         assign legal  = op_legal(op);
         assign exists = (count > OCC_W'(gi));

         always_comb begin
            credit_ok = (add_free > add_used[gi]);
            if (cls == CLS_LD)
               credit_ok = (ld_free > ld_used[gi]);
            else if (cls == CLS_SD)
               credit_ok = (sd_free > sd_used[gi]);
         end

         assign slot_valid[gi]         = alive[gi] && exists && legal && credit_ok;
         // An illegal entry is consumed only where the chain actually reaches it;
         // it is never dispatched and it ends the chain for this cycle.
         assign slot_ill[gi]           = alive[gi] && exists && !legal;
         assign slot_bne[gi]           = slot_valid[gi] && (op == OP_BNE);
         assign slot_cls[gi*2 +: 2]    = slot_valid[gi] ? cls : CLS_ADD;

         if (gi < ISSUE_W - 1) begin : g_next
            assign alive[gi+1]    = slot_valid[gi] && !slot_bne[gi];
            assign add_used[gi+1] = add_used[gi] + CNT_W'(slot_valid[gi] && (cls == CLS_ADD));
            assign ld_used[gi+1]  = ld_used[gi]  + CNT_W'(slot_valid[gi] && (cls == CLS_LD));
            assign sd_used[gi+1]  = sd_used[gi]  + CNT_W'(slot_valid[gi] && (cls == CLS_SD));
         end
      end
   endgenerate

   assign illegal    = |slot_ill;
   assign bne_issued = |slot_bne;

   always_comb begin
      deq_cnt = '0;
      for (int i = 0; i < ISSUE_W; i++)
         deq_cnt = deq_cnt + CNT_W'(slot_valid[i] | slot_ill[i]);
   end

endmodule

// File: rtl/tomasulo_issue_queue.sv
// tomasulo_issue_queue: in-order instruction queue with ISSUE_W-wide dispatch
// into the adder RS, load buffer and store buffer.  Dispatch stalls behind a
// BNE until it resolves; a taken branch flushes everything queued.
// Ports:
//  Clock, Reset      clock (rising edge), synchronous active-low reset
//  Run               dispatch enable (enqueue is independent of it)
//  enq_valid/inst    instruction from fetch; enq_ready accepts it
//  add/ld/sd_free    free entries per class this cycle
//  iss_valid/inst/cls  per-slot dispatch, slot 0 = oldest
//  br_resolve/taken  resolution of the outstanding BNE
//  illegal           pulse: undefined opcode discarded at the head
//  count             occupied entries
module tomasulo_issue_queue
   import tomasulo_pkg::*;
#(
   parameter  int INST_W  = 16,
   parameter  int DEPTH   = 16,
   parameter  int ISSUE_W = 2,
   localparam int CNT_W   = $clog2(ISSUE_W + 1),
   localparam int PTR_W   = $clog2(DEPTH),
   localparam int OCC_W   = PTR_W + 1
) (
   input  logic                        Clock,
   input  logic                        Reset,
   input  logic                        Run,
   input  logic                        enq_valid,
   input  logic [INST_W-1:0]           enq_inst,
   output logic                        enq_ready,
   input  logic [CNT_W-1:0]            add_free,
   input  logic [CNT_W-1:0]            ld_free,
   input  logic [CNT_W-1:0]            sd_free,
   output logic [ISSUE_W-1:0]          iss_valid,
   output logic [ISSUE_W*INST_W-1:0]   iss_inst,
   output logic [ISSUE_W*2-1:0]        iss_cls,
   input  logic                        br_resolve,
   input  logic                        br_taken,
   output logic                        illegal,
   output logic [OCC_W-1:0]            count
);

   logic [INST_W-1:0]          mem [DEPTH];
   logic [PTR_W-1:0]           head_reg, head_next;
   logic [PTR_W-1:0]           tail_reg, tail_next;
   logic [OCC_W-1:0]           count_reg, count_next;
   iq_state_t                  state_reg, state_next;

   logic                       enq_fire;
   logic                       flush;
   logic                       dispatch_en;
   logic                       bne_issued;
   logic                       slot_illegal;
   logic [CNT_W-1:0]           deq_cnt;
   logic [ISSUE_W-1:0]         slot_valid;
   logic [ISSUE_W*2-1:0]       slot_cls;
   logic [ISSUE_W*INST_W-1:0]  head_inst;
   logic [ISSUE_W*4-1:0]       head_op;

   assign flush       = (state_reg == ST_BR_WAIT) && br_resolve && br_taken;
   // A taken resolve blocks enqueue so the flushed queue comes back truly empty.
   assign enq_ready   = Reset && (count_reg != OCC_W'(DEPTH)) && !(br_resolve && br_taken);
   assign enq_fire    = enq_valid && enq_ready;
   assign dispatch_en = Reset && Run && (state_reg == ST_RUN);

   genvar gi;
   generate
      for (gi = 0; gi < ISSUE_W; gi++) begin : g_head
         // Pointer arithmetic wraps naturally at PTR_W bits.
         assign head_inst[gi*INST_W +: INST_W] = mem[head_reg + PTR_W'(gi)];
         assign head_op[gi*4 +: 4]             = head_inst[gi*INST_W +: 4];
         assign iss_inst[gi*INST_W +: INST_W]  =
            slot_valid[gi] ? head_inst[gi*INST_W +: INST_W] : '0;
      end
   endgenerate

   iq_slot_select #(
      .ISSUE_W (ISSUE_W),
      .CNT_W   (CNT_W),
      .OCC_W   (OCC_W)
   ) u_slot_select (
      .enable     (dispatch_en),
      .count      (count_reg),
      .head_op    (head_op),
      .add_free   (add_free),
      .ld_free    (ld_free),
      .sd_free    (sd_free),
      .slot_valid (slot_valid),
      .slot_cls   (slot_cls),
      .illegal    (slot_illegal),
      .deq_cnt    (deq_cnt),
      .bne_issued (bne_issued)
   );

   assign iss_valid = slot_valid;
   assign iss_cls   = slot_cls;
   assign illegal   = slot_illegal;
   assign count     = count_reg;

   // Storage is not reset; occupancy alone decides which entries are live.
   always_ff @(posedge Clock) begin
      if (enq_fire)
         mem[tail_reg] <= enq_inst;
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         state_reg <= ST_RUN;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      head_next  = head_reg + PTR_W'(deq_cnt);
      tail_next  = tail_reg + PTR_W'(enq_fire);
      count_next = count_reg + OCC_W'(enq_fire) - OCC_W'(deq_cnt);

      case (state_reg)
         ST_RUN: begin
            // A dispatched BNE is always the youngest slot of its cycle.
            if (bne_issued)
               state_next = ST_BR_WAIT;
         end
         ST_BR_WAIT: begin
            if (br_resolve)
               state_next = ST_RUN;
         end
         default: state_next = ST_RUN;
      endcase

      // No dispatch happens in BR_WAIT and enqueue is blocked, so the
      // flush simply collapses the queue onto the tail.
      if (flush) begin
         head_next  = tail_reg;
         count_next = '0;
      end
   end

endmodule

// File: tb/tb_tomasulo_issue_queue.sv
module tb_tomasulo_issue_queue;

   logic        Clock;
   logic        Reset;
   logic        Run;
   logic        enq_valid;
   logic [15:0] enq_inst;
   logic        enq_ready;
   logic [1:0]  add_free, ld_free, sd_free;
   logic [1:0]  iss_valid;
   logic [31:0] iss_inst;
   logic [3:0]  iss_cls;
   logic        br_resolve, br_taken;
   logic        illegal;
   logic [4:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   tomasulo_issue_queue #(
      .INST_W  (16),
      .DEPTH   (16),
      .ISSUE_W (2)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Run        (Run),
      .enq_valid  (enq_valid),
      .enq_inst   (enq_inst),
      .enq_ready  (enq_ready),
      .add_free   (add_free),
      .ld_free    (ld_free),
      .sd_free    (sd_free),
      .iss_valid  (iss_valid),
      .iss_inst   (iss_inst),
      .iss_cls    (iss_cls),
      .br_resolve (br_resolve),
      .br_taken   (br_taken),
      .illegal    (illegal),
      .count      (count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The queue is a plain list of instructions; the walk below applies the
   // dispatch rules directly to the oldest ISSUE_W of them.
   logic [15:0] q[$];
   bit          m_wait  = 0;
   bit          chk_en  = 0;
   int          p_deq   = 0;
   bit          p_enq   = 0;
   logic [15:0] p_inst  = '0;
   bit          p_bne   = 0;
   bit          p_res   = 0;
   bit          p_flush = 0;

   initial begin : compare_proc
      logic [1:0]  ev;
      logic [31:0] ei;
      logic [3:0]  ec;
      logic        eill;
      logic        erdy;
      logic [15:0] e;
      logic [3:0]  op;
      int          fr[3];
      int          used[3];
      int          c;
      int          nd;
      bit          bne;
      forever begin
         @(negedge Clock);
         if (chk_en) begin
            ev = '0; ei = '0; ec = '0; eill = 0; nd = 0; bne = 0;
            used[0] = 0; used[1] = 0; used[2] = 0;
            fr[0] = int'(add_free); fr[1] = int'(ld_free); fr[2] = int'(sd_free);
            erdy = Reset && (q.size() != 16) && !(br_resolve && br_taken);
            if (Reset && Run && !m_wait) begin
               for (int i = 0; i < 2; i++) begin
                  if (i >= q.size()) break;
                  e  = q[i];
                  op = e[3:0];
                  if (op > 4'd4) begin
                     eill = 1; nd++;
                     break;
                  end
                  c = (op == 4'd3) ? 1 : (op == 4'd4) ? 2 : 0;
                  if (fr[c] <= used[c]) break;
                  used[c]++;
                  ev[i] = 1'b1;
                  ei[i*16 +: 16] = e;
                  ec[i*2 +: 2] = 2'(c);
                  nd++;
                  if (op == 4'd2) begin
                     bne = 1;
                     break;
                  end
               end
            end
            chk("cyc_iss_valid", {30'd0, iss_valid}, {30'd0, ev});
            chk("cyc_iss_inst", iss_inst, ei);
            chk("cyc_iss_cls", {28'd0, iss_cls}, {28'd0, ec});
            chk("cyc_illegal", {31'd0, illegal}, {31'd0, eill});
            chk("cyc_enq_ready", {31'd0, enq_ready}, {31'd0, erdy});
            chk("cyc_count", {27'd0, count}, 32'(q.size()));
            if (iss_valid != 2'b00 || illegal)
               $display("[TB] t=%0t issue valid=%b inst=%h cls=%b illegal=%b count=%0d",
                        $time, iss_valid, iss_inst, iss_cls, illegal, count);
            p_deq   = nd;
            p_enq   = enq_valid && erdy;
            p_inst  = enq_inst;
            p_bne   = bne;
            p_res   = m_wait && br_resolve;
            p_flush = m_wait && br_resolve && br_taken;
         end
      end
   end

   initial begin : model_update
      forever begin
         @(posedge Clock);
         if (!Reset) begin
            q.delete();
            m_wait = 0;
            chk_en = 1;
            p_deq = 0; p_enq = 0; p_bne = 0; p_res = 0; p_flush = 0;
         end else if (chk_en) begin
            for (int k = 0; k < p_deq; k++) void'(q.pop_front());
            if (p_flush) q.delete();
            if (p_enq) q.push_back(p_inst);
            if (p_bne) m_wait = 1;
            else if (p_res) m_wait = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge Clock);
      #1;
   endtask

   task automatic enq(input logic [15:0] inst);
      enq_valid = 1'b1;
      enq_inst  = inst;
      cyc();
      enq_valid = 1'b0;
   endtask

   initial begin
      Reset = 1'b0; Run = 1'b1; enq_valid = 1'b0; enq_inst = '0;
      add_free = 2'd2; ld_free = 2'd2; sd_free = 2'd2;
      br_resolve = 1'b0; br_taken = 1'b0;

      // 1: reset, then ADD,SUB,ADD,SUB two-wide
      cyc(); cyc();
      #2;
      chk("rst_count", {27'd0, count}, 32'd0);
      chk("rst_iss_valid", {30'd0, iss_valid}, 32'd0);
      chk("rst_enq_ready", {31'd0, enq_ready}, 32'd0);
      Reset = 1'b1;
      #1;
      chk("rst_release_ready", {31'd0, enq_ready}, 32'd1);
      cyc();
      Run = 1'b0;
      enq(16'h1000); enq(16'h2001); enq(16'h3000); enq(16'h4001);
      Run = 1'b1;
      #2;
      chk("t1_count4", {27'd0, count}, 32'd4);
      chk("t1_valid_a", {30'd0, iss_valid}, 32'd3);
      chk("t1_inst_a", iss_inst, 32'h2001_1000);
      cyc(); #2;
      chk("t1_count2", {27'd0, count}, 32'd2);
      chk("t1_inst_b", iss_inst, 32'h4001_3000);
      cyc(); #2;
      chk("t1_count0", {27'd0, count}, 32'd0);
      chk("t1_valid_c", {30'd0, iss_valid}, 32'd0);

      // 2: LD stream with ld_free=1 then 2
      Run = 1'b0; ld_free = 2'd1;
      enq(16'h5003); enq(16'h6003); enq(16'h7003);
      Run = 1'b1; #2;
      chk("t2_ld1_a", iss_inst, 32'h0000_5003);
      chk("t2_ld1_cls", {28'd0, iss_cls}, 32'h1);
      cyc(); #2;
      chk("t2_ld1_b", iss_inst, 32'h0000_6003);
      cyc(); #2;
      chk("t2_ld1_c", iss_inst, 32'h0000_7003);
      cyc(); #2;
      chk("t2_ld1_empty", {30'd0, iss_valid}, 32'd0);
      Run = 1'b0; ld_free = 2'd2;
      enq(16'h5003); enq(16'h6003); enq(16'h7003);
      Run = 1'b1; #2;
      chk("t2_ld2_a", {30'd0, iss_valid}, 32'd3);
      cyc(); #2;
      chk("t2_ld2_b", {30'd0, iss_valid}, 32'd1);
      cyc();

      // mixed classes with a starved store buffer
      Run = 1'b0; ld_free = 2'd1; sd_free = 2'd0;
      enq(16'h1230); enq(16'h1233); enq(16'h1234);
      Run = 1'b1; #2;
      chk("mix_valid", {30'd0, iss_valid}, 32'd3);
      chk("mix_cls", {28'd0, iss_cls}, 32'h4);
      cyc(); #2;
      chk("mix_sd_blocked", {30'd0, iss_valid}, 32'd0);
      sd_free = 2'd1; #1;
      chk("mix_sd_cls", {28'd0, iss_cls}, 32'h2);
      cyc();
      ld_free = 2'd2; sd_free = 2'd2;

      // 3: ADD,BNE,SUB; not-taken resolve
      Run = 1'b0;
      enq(16'h8000); enq(16'h9002); enq(16'hA001);
      Run = 1'b1; #2;
      chk("t3_valid", {30'd0, iss_valid}, 32'd3);
      chk("t3_inst", iss_inst, 32'h9002_8000);
      cyc(); #2; chk("t3_stall1", {30'd0, iss_valid}, 32'd0);
      cyc(); #2; chk("t3_stall2", {30'd0, iss_valid}, 32'd0);
      cyc(); #2; chk("t3_stall3", {30'd0, iss_valid}, 32'd0);
      cyc();
      br_resolve = 1'b1; br_taken = 1'b0; #2;
      chk("t3_resolve_cyc", {30'd0, iss_valid}, 32'd0);
      cyc();
      br_resolve = 1'b0; #2;
      chk("t3_sub", iss_inst, 32'h0000_A001);
      cyc();

      // 4: taken resolve with 5 queued and a simultaneous enqueue
      enq(16'hB002); #2;
      chk("t4_bne", {30'd0, iss_valid}, 32'd1);
      cyc();
      enq(16'h0010); enq(16'h0020); enq(16'h0030); enq(16'h0040); enq(16'h0050);
      #2;
      chk("t4_count5", {27'd0, count}, 32'd5);
      br_resolve = 1'b1; br_taken = 1'b1; enq_valid = 1'b1; enq_inst = 16'hC000; #2;
      chk("t4_enq_ready", {31'd0, enq_ready}, 32'd0);
      cyc();
      br_resolve = 1'b0; br_taken = 1'b0; enq_valid = 1'b0; #2;
      chk("t4_count0", {27'd0, count}, 32'd0);
      enq(16'hD000); #2;
      chk("t4_after_flush", iss_inst, 32'h0000_D000);
      cyc();

      // 5: fill to 16, then refill across the pointer wrap
      Run = 1'b0;
      for (int k = 0; k < 16; k++) enq(16'(k) << 8);
      enq_valid = 1'b1; enq_inst = 16'hEEE0; #2;
      chk("t5_full", {27'd0, count}, 32'd16);
      chk("t5_full_ready", {31'd0, enq_ready}, 32'd0);
      cyc();
      enq_valid = 1'b0;
      Run = 1'b1; #2;
      chk("t5_first", iss_inst, 32'h0100_0000);
      cyc();
      Run = 1'b0;
      enq(16'hF100); enq(16'hF110);
      #2; chk("t5_refull", {27'd0, count}, 32'd16);
      Run = 1'b1;
      for (int j = 0; j < 8; j++) begin
         #2;
         if (j == 7) chk("t5_wrap_tail", iss_inst, 32'hF110_F100);
         cyc();
      end
      #2; chk("t5_drained", {27'd0, count}, 32'd0);

      // 6: illegal opcodes
      Run = 1'b0;
      enq(16'h0007); enq(16'hE000);
      #2; chk("t6_ill_run0", {31'd0, illegal}, 32'd0);
      Run = 1'b1; #2;
      chk("t6_illegal", {31'd0, illegal}, 32'd1);
      chk("t6_ill_valid", {30'd0, iss_valid}, 32'd0);
      cyc(); #2;
      chk("t6_add_next", iss_inst, 32'h0000_E000);
      chk("t6_ill_clear", {31'd0, illegal}, 32'd0);
      cyc();
      Run = 1'b0;
      enq(16'h0100); enq(16'h000F); enq(16'h0201);
      Run = 1'b1; #2;
      chk("t6_slot1_ill", {31'd0, illegal}, 32'd1);
      chk("t6_slot1_valid", {30'd0, iss_valid}, 32'd1);
      cyc(); #2;
      chk("t6_slot1_count", {27'd0, count}, 32'd1);
      cyc();

      // reset mid-stream
      Run = 1'b0;
      enq(16'h0300); enq(16'h0400); enq(16'h0500);
      Run = 1'b1; #2;
      Reset = 1'b0;
      cyc(); #2;
      chk("rst_mid_count", {27'd0, count}, 32'd0);
      chk("rst_mid_valid", {30'd0, iss_valid}, 32'd0);
      chk("rst_mid_inst", iss_inst, 32'd0);
      Reset = 1'b1;
      cyc();

      // reset while waiting on a branch
      enq(16'h0602); cyc(); #2;
      chk("rst_brw_stall", {30'd0, iss_valid}, 32'd0);
      Reset = 1'b0;
      cyc();
      Reset = 1'b1;
      enq(16'hABC0); #2;
      chk("rst_brw_resume", iss_inst, 32'h0000_ABC0);
      cyc(); cyc();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
